uart_mmio: RTL

- Memory-mapped UART peripheral on the CPU data-memory bus (`dmem_*`), directly downstream of the cpu core.
- Provides a TX FIFO, a single-byte RX holding register, status and control registers, and a level interrupt that drives the cpu `irq` input.
- Read data is OR-muxed with the other dmem slaves, so the block outputs 0 when it is not selected.

---
 rtl/uart_mmio.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped UART: TX FIFO + shifter, single-byte RX holding register,
// status/control registers and a level interrupt for the cpu dmem bus.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module uart_mmio #(
  parameter int                     CLOCK_HZ  = 27000000,
  parameter int                     BAUD      = 115200,
  parameter logic [`ADDR_WIDTH-1:0] BASE_ADDR = `ADDR_WIDTH'(16'h0020),
  parameter int                     TX_DEPTH  = 8
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic [`ADDR_WIDTH-1:0] dmem_addr,
  input  logic                   dmem_ren,
  input  logic                   dmem_wen,
  input  logic                   dmem_byt,
  input  logic [15:0]            dmem_wdata,
  output logic [15:0]            dmem_rdata,
  output logic                   irq,
  input  logic                   uart_rx,
  output logic                   uart_tx
);

  localparam int DIV = (CLOCK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(TX_DEPTH);

  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [AW:0]   FIFO_CAP = (AW + 1)'(TX_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------- decode
  logic       w_sel;
  logic [1:0] w_off;
  logic       w_wr;
  logic       w_rd;
  logic       w_data_wr;
  logic       w_data_rd;
  logic       w_stat_wr;
  logic       w_ctrl_wr;
  logic       w_unused;

  assign w_sel     = (dmem_addr[`ADDR_WIDTH-1:3] == BASE_ADDR[`ADDR_WIDTH-1:3]);
  assign w_off     = dmem_addr[2:1];
  // Odd-address byte writes would target the upper byte, which no register has.
  assign w_wr      = dmem_wen & w_sel & ~(dmem_byt & dmem_addr[0]);
  assign w_rd      = dmem_ren & w_sel;
  assign w_data_wr = w_wr & (w_off == 2'd0);
  assign w_stat_wr = w_wr & (w_off == 2'd1);
  assign w_ctrl_wr = w_wr & (w_off == 2'd2);
  assign w_data_rd = w_rd & (w_off == 2'd0);
  assign w_unused  = ^dmem_wdata[15:8];

  // ------------------------------------------------------------ registers
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_fifo [TX_DEPTH];

  logic [1:0]    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx;

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_d;
  logic [1:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;

  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;
  logic          r_rx_overrun;
  logic          r_frame_err;
  logic          r_tx_drop;
  logic [1:0]    r_ctrl;
  logic [15:0]   r_rdata;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_tx_idle;
  logic          w_rx_end;
  logic          w_rx_done;
  logic          w_rx_ferr;
  logic          w_load;
  logic          w_ovr_set;
  logic [15:0]   w_rd_mux;

  assign w_empty   = (r_count == (AW + 1)'(0));
  assign w_full    = (r_count == FIFO_CAP);
  // The shifter pulls a byte from IDLE, or straight out of STOP so frames abut.
  assign w_pop     = ~w_empty & ((r_tx_state == S_IDLE) |
                                 ((r_tx_state == S_STOP) & (r_tx_cnt == BIT_END)));
  assign w_push    = w_data_wr & (~w_full | w_pop);
  assign w_drop    = w_data_wr & w_full & ~w_pop;
  assign w_tx_idle = w_empty & (r_tx_state == S_IDLE);

  assign w_rx_end  = (r_rx_state == S_STOP) & (r_rx_cnt == BIT_END);
  assign w_rx_done = w_rx_end & r_rx_s2;
  assign w_rx_ferr = w_rx_end & ~r_rx_s2;
  assign w_load    = w_rx_done & (~r_rx_valid | w_data_rd);
  assign w_ovr_set = w_rx_done & r_rx_valid & ~w_data_rd;

  // ------------------------------------------------------------- TX FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW + 1)'(0);
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= dmem_wdata[7:0];
  end

  // ------------------------------------------------------------- TX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= CW'(0);
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_cnt <= CW'(0);
          if (w_pop) begin
            r_tx_shift <= r_fifo[r_rptr];
            r_tx       <= 1'b0;
            r_tx_state <= S_START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        S_START: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= CW'(0);
            r_tx_bit   <= 3'd0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt <= CW'(0);
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= S_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx       <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt <= CW'(0);
            if (w_pop) begin
              r_tx_shift <= r_fifo[r_rptr];
              r_tx       <= 1'b0;
              r_tx_state <= S_START;
            end else begin
              r_tx       <= 1'b1;
              r_tx_state <= S_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- RX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= CW'(0);
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: begin
          r_rx_cnt <= CW'(0);
          if (r_rx_d & ~r_rx_s2) r_rx_state <= S_START;
        end
        S_START: begin
          // Half-bit check rejects glitches and centres later samples.
          if (r_rx_cnt == HALF_END) begin
            r_rx_cnt   <= CW'(0);
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt   <= CW'(0);
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt   <= CW'(0);
            r_rx_state <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ----------------------------------------------- status / control regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_byte    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_drop    <= 1'b0;
      r_ctrl       <= 2'b00;
    end else begin
      if (w_load) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_data_rd) begin
        r_rx_valid <= 1'b0;
      end
      // Sets take priority over write-one-to-clear in the same cycle.
      r_rx_overrun <= (r_rx_overrun & ~(w_stat_wr & dmem_wdata[1])) | w_ovr_set;
      r_frame_err  <= (r_frame_err  & ~(w_stat_wr & dmem_wdata[4])) | w_rx_ferr;
      r_tx_drop    <= (r_tx_drop    & ~(w_stat_wr & dmem_wdata[5])) | w_drop;
      if (w_ctrl_wr) r_ctrl <= dmem_wdata[1:0];
    end
  end

  // Register read multiplexer
  always_comb begin
    w_rd_mux = 16'h0000;
    case (w_off)
      2'd0:    w_rd_mux = {8'h00, r_rx_byte};
      2'd1:    w_rd_mux = {10'h000, r_tx_drop, r_frame_err, w_tx_idle,
                           w_full, r_rx_overrun, r_rx_valid};
      2'd2:    w_rd_mux = {14'h0000, r_ctrl};
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // Read data holds until the next sampled read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 16'h0000;
    end else if (dmem_ren) begin
      r_rdata <= w_sel ? w_rd_mux : 16'h0000;
    end
  end

  assign dmem_rdata = r_rdata;
  assign uart_tx    = r_tx;
  assign irq        = (r_ctrl[0] & r_rx_valid) | (r_ctrl[1] & w_tx_idle);

endmodule
